// File: rtl/enigma_pkg.sv
// Shared constants and helpers for the stepping Enigma engine: alphabet size,
// rotor type codes, notch positions, rotor/reflector wiring and mod-26 arithmetic.
package enigma_pkg;

  localparam int ALPHA = 26;

  localparam logic [1:0] ROTOR_I   = 2'd0;
  localparam logic [1:0] ROTOR_II  = 2'd1;
  localparam logic [1:0] ROTOR_III = 2'd2;

  // Type code 3 is unused and behaves as rotor III.
  localparam logic [4:0] NOTCH [4] = '{5'd16, 5'd4, 5'd21, 5'd21};

  localparam logic [4:0] WIRING [3][ALPHA] = '{
    '{5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
      5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9},
    '{5'd0, 5'd9, 5'd3, 5'd10, 5'd18, 5'd8, 5'd17, 5'd20, 5'd23, 5'd1, 5'd11, 5'd7, 5'd22,
      5'd19, 5'd12, 5'd2, 5'd16, 5'd6, 5'd25, 5'd13, 5'd15, 5'd24, 5'd5, 5'd21, 5'd14, 5'd4},
    '{5'd1, 5'd3, 5'd5, 5'd7, 5'd9, 5'd11, 5'd2, 5'd15, 5'd17, 5'd19, 5'd23, 5'd21, 5'd25,
      5'd13, 5'd24, 5'd4, 5'd8, 5'd22, 5'd6, 5'd0, 5'd10, 5'd12, 5'd20, 5'd18, 5'd16, 5'd14}
  };

  // Reflector B
  localparam logic [4:0] REFL_B [ALPHA] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19
  };

  // Returns {valid, index}; valid is set only for an exactly-one-hot letter.
  function automatic logic [5:0] onehot_to_idx(input logic [ALPHA-1:0] oh);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < ALPHA; i++) begin
      if (oh[i]) idx = 5'(i);
    end
    return {$onehot(oh), idx};
  endfunction

  function automatic logic [4:0] inc_mod26(input logic [4:0] x);
    return (x == 5'd25) ? 5'd0 : x + 5'd1;
  endfunction

  function automatic logic [4:0] add_mod26(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 6'd26) ? 5'(s - 6'd26) : s[4:0];
  endfunction

  function automatic logic [4:0] sub_mod26(input logic [4:0] a, input logic [4:0] b);
    return (a >= b) ? a - b : 5'(6'd26 + {1'b0, a} - {1'b0, b});
  endfunction

  function automatic int type_idx(input logic [1:0] t);
    return (t == 2'd3) ? 2 : int'(t);
  endfunction

  function automatic logic [4:0] rotor_fwd(input logic [1:0] t, input logic [4:0] x,
                                           input logic [4:0] p);
    return sub_mod26(WIRING[type_idx(t)][add_mod26(x, p)], p);
  endfunction

  function automatic logic [4:0] rotor_inv(input logic [1:0] t, input logic [4:0] x,
                                           input logic [4:0] p);
    logic [4:0] y;
    logic [4:0] j_hit;
    y = add_mod26(x, p);
    j_hit = '0;
    for (int j = 0; j < ALPHA; j++) begin
      if (WIRING[type_idx(t)][j] == y) j_hit = 5'(j);
    end
    return sub_mod26(j_hit, p);
  endfunction

  function automatic logic [4:0] reflect(input logic [4:0] x);
    return REFL_B[x];
  endfunction

endpackage

// File: rtl/enigma_core.sv
// Combinational cipher path: fast rotor to slow rotor, reflector, then back
// through the inverse rotors. The plugboard is unwired (identity).
module enigma_core
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter logic [2*NUM_ROTORS-1:0] ROTOR_TYPES = {2'd2, 2'd1, 2'd0}
) (
  input  logic [ALPHA-1:0]        letter,
  input  logic [5*NUM_ROTORS-1:0] pos_in,
  output logic [ALPHA-1:0]        letter_out
);

  logic [5:0] in_idx;
  logic [4:0] fwd [NUM_ROTORS+1];
  logic [4:0] bwd [NUM_ROTORS+1];

  assign in_idx = onehot_to_idx(letter);
  assign fwd[0] = in_idx[4:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROTORS; gi++) begin : g_rotor
      assign fwd[gi+1] = rotor_fwd(ROTOR_TYPES[2*gi +: 2], fwd[gi], pos_in[5*gi +: 5]);
      assign bwd[gi]   = rotor_inv(ROTOR_TYPES[2*gi +: 2], bwd[gi+1], pos_in[5*gi +: 5]);
    end
  endgenerate

  assign bwd[NUM_ROTORS] = reflect(fwd[NUM_ROTORS]);

  // Illegal (non-one-hot) letters encipher to all-zero.
  assign letter_out = in_idx[5] ? (ALPHA'(1) << bwd[0]) : '0;

endmodule

// File: rtl/enigma_stepper.sv
// Stepping Enigma engine with valid/ready in and out, two-stage pipeline,
// key load and sticky error. Optional letter counter: ENIGMA_LETTER_COUNT_EN.
module enigma_stepper
  import enigma_pkg::*;
#(
  parameter int NUM_ROTORS = 3,
  parameter logic [2*NUM_ROTORS-1:0] ROTOR_TYPES = {2'd2, 2'd1, 2'd0}
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ALPHA-1:0]        in_letter,
  input  logic                    load,
  input  logic [5*NUM_ROTORS-1:0] load_pos,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ALPHA-1:0]        out_letter,
  output logic [5*NUM_ROTORS-1:0] pos,
  output logic                    err
`ifdef ENIGMA_LETTER_COUNT_EN
  ,
  output logic [31:0]             letter_cnt
`endif
);

  logic [5*NUM_ROTORS-1:0] pos_reg, a_pos_reg, pos_stepped, pos_loaded;
  logic [ALPHA-1:0]        a_letter_reg, out_letter_reg, core_out;
  logic                    a_valid_reg, out_valid_reg, err_reg, live_reg;
  logic [NUM_ROTORS-1:0]   do_step;
  logic                    b_adv, accept, in_legal;

  assign b_adv    = !out_valid_reg || out_ready;
  assign in_ready = live_reg && (!a_valid_reg || b_adv) && !load;
  assign accept   = in_valid && in_ready;
  assign in_legal = $onehot(in_letter);

  // Odometer stepping; all notch tests look at the pre-step positions.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_ROTORS; gi++) begin : g_step
      logic [4:0] cur, ld;
      assign cur = pos_reg[5*gi +: 5];
      assign ld  = load_pos[5*gi +: 5];
      if (gi == 0) begin : g_fast
        assign do_step[gi] = 1'b1;
      end else begin : g_upper
        localparam logic [1:0] PTYPE = ROTOR_TYPES[2*(gi-1) +: 2];
        logic prev_notch, self_notch;
        assign prev_notch = (pos_reg[5*(gi-1) +: 5] == NOTCH[PTYPE]);
        if (gi <= NUM_ROTORS - 2) begin : g_middle
          localparam logic [1:0] TYPE = ROTOR_TYPES[2*gi +: 2];
          assign self_notch = (cur == NOTCH[TYPE]);
        end else begin : g_last
          assign self_notch = 1'b0;
        end
        assign do_step[gi] = prev_notch || self_notch;
      end
      assign pos_stepped[5*gi +: 5] = do_step[gi] ? inc_mod26(cur) : cur;
      assign pos_loaded[5*gi +: 5]  = (ld >= 5'd26) ? ld - 5'd26 : ld;
    end
  endgenerate

  enigma_core #(
    .NUM_ROTORS (NUM_ROTORS),
    .ROTOR_TYPES(ROTOR_TYPES)
  ) u_core (
    .letter    (a_letter_reg),
    .pos_in    (a_pos_reg),
    .letter_out(core_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live_reg       <= 1'b0;
      pos_reg        <= '0;
      err_reg        <= 1'b0;
      a_valid_reg    <= 1'b0;
      a_letter_reg   <= '0;
      a_pos_reg      <= '0;
      out_valid_reg  <= 1'b0;
      out_letter_reg <= '0;
    end else begin
      live_reg <= 1'b1;
      if (load) begin
        pos_reg <= pos_loaded;
      end else if (accept && in_legal) begin
        pos_reg <= pos_stepped;
      end
      if (accept && !in_legal) begin
        err_reg <= 1'b1;
      end
      // Stage A snapshots the positions the letter is enciphered with.
      if (accept) begin
        a_valid_reg  <= 1'b1;
        a_letter_reg <= in_letter;
        a_pos_reg    <= in_legal ? pos_stepped : pos_reg;
      end else if (b_adv) begin
        a_valid_reg <= 1'b0;
      end
      if (b_adv) begin
        out_valid_reg <= a_valid_reg;
        if (a_valid_reg) begin
          out_letter_reg <= core_out;
        end
      end
    end
  end

`ifdef ENIGMA_LETTER_COUNT_EN
  logic [31:0] cnt_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= '0;
    end else if (accept && in_legal && (cnt_reg != 32'hFFFF_FFFF)) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end
  assign letter_cnt = cnt_reg;
`else
  // Letter counter not built.
`endif

  assign out_valid  = out_valid_reg;
  assign out_letter = out_letter_reg;
  assign pos        = pos_reg;
  assign err        = err_reg;

endmodule
